// File: rtl/rr_dec_arbiter.sv
// -----------------------------------------------------------------------------
// rr_dec_arbiter
//   Round-robin arbiter that shares the outputs of a 2-to-4 decoder (GM_2S4)
//   between four requesters. One owner is chosen per grant window. The arbiter
//   drives the 2-bit encoded select (SEL[1]=I1, SEL[0]=I0) and a one-hot grant
//   that is gated by VALID. An owner that has a competitor keeps the grant for
//   at most HOLD_MAX cycles. The owner is then searched last, so the grant
//   rotates fairly. All outputs are registered.
//
// Parameters
//   HOLD_MAX  max consecutive grant cycles while others wait (1..15)
//
// Ports
//   CLK    in   1  system clock, rising edge
//   RST_N  in   1  synchronous reset, active-low
//   LOCK   in   1  only with RR_DEC_LOCK_EN: suppresses the hold timeout
//   REQ    in   4  request per requester, bit n = requester n
//   SEL    out  2  encoded owner index
//   VALID  out  1  a grant is active
//   GNT    out  4  one-hot grant = decode(SEL) when VALID, else 0
//
// Optional feature macro: RR_DEC_LOCK_EN (adds the LOCK input)
// -----------------------------------------------------------------------------
module rr_dec_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
`ifdef RR_DEC_LOCK_EN
  input  logic       LOCK,
`endif
  input  logic [3:0] REQ,
  output logic [1:0] SEL,
  output logic       VALID,
  output logic [3:0] GNT
);

  localparam logic [3:0] HOLD_CNT = 4'(HOLD_MAX);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] sel_nxt;
  logic       valid_nxt;
  logic [3:0] gnt_nxt;

  logic [3:0] owner_oh;
  logic       owner_req;
  logic       others_req;
  logic       lock_hold;
  logic       timeout;
  logic       release_grant;
  logic       arbitrate;
  logic [2:0] pick;

  // Returns {found, index}. The search starts one past the pointer and wraps,
  // so the last winner is considered last.
  function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [3:0] req);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef RR_DEC_LOCK_EN
  assign lock_hold = VALID & LOCK;
`else
  assign lock_hold = 1'b0;
`endif

  assign owner_oh      = 4'b0001 << SEL;
  assign owner_req     = REQ[SEL];
  assign others_req    = |(REQ & ~owner_oh);
  assign timeout       = (cnt == HOLD_CNT) && others_req && !lock_hold;
  assign release_grant = (state == GRANT) && (!owner_req || timeout);
  assign arbitrate     = (state == IDLE) || release_grant;
  assign pick          = rr_pick(ptr, REQ);

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      ptr   <= 2'd3;
      cnt   <= 4'd0;
      SEL   <= 2'b00;
      VALID <= 1'b0;
      GNT   <= 4'b0000;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      SEL   <= sel_nxt;
      VALID <= valid_nxt;
      GNT   <= gnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    sel_nxt   = SEL;
    if (arbitrate) begin
      if (pick[2]) begin
        state_nxt = GRANT;
        ptr_nxt   = pick[1:0];
        sel_nxt   = pick[1:0];
        cnt_nxt   = 4'd1;
      end else begin
        // SEL and PTR hold so the next search still rotates from the last owner.
        state_nxt = IDLE;
      end
    end else if (cnt != HOLD_CNT) begin
      cnt_nxt = cnt + 4'd1;
    end
  end

  // Output logic (registered through the state register).
  always_comb begin
    valid_nxt = (state_nxt == GRANT);
    gnt_nxt   = valid_nxt ? (4'b0001 << sel_nxt) : 4'b0000;
  end

endmodule
